imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, registered immediate-extension stage for the five-stage datapath. Widens an IN_WIDTH immediate to OUT_WIDTH under a per-transaction mode (sign, zero, upper-placement, or branch-offset sign-extend-and-shift-by-2). It sits between instruction decode and the ID/EX boundary. A valid/ready handshake with an optional skid buffer lets decode stall without losing immediates.

## Interface
Parameters:
- IN_WIDTH, 16, immediate field width; must be ≥ 2.
- OUT_WIDTH, 32, extended result width; must be ≥ IN_WIDTH+2; a smaller value is an elaboration error.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  In and Mode are presented.
- InReady  output  1  the block accepts this cycle.
- In  input  IN_WIDTH  raw immediate.
- Mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
- OutValid  output  1  Out holds a result.
- OutReady  input  1  downstream accepts this cycle.
- Out  output  OUT_WIDTH  extended result.
- OutMode  output  2  Mode that produced Out.

## Operation
- Accept when InValid && InReady. Deliver when OutValid && OutReady.
- Results are computed combinationally from In/Mode and written into the output register on accept. Let E = OUT_WIDTH−IN_WIDTH.
- Mode 00: E copies of In[IN_WIDTH−1], then In.
- Mode 01: E zeros, then In.
- Mode 10: In in the MSBs, then E zeros (LUI form).
- Mode 11: sign-extend In to OUT_WIDTH−2 bits, then append 2'b00. The top two bits of a plain sign-extension are discarded.
- Results leave in strict acceptance order. None are dropped or duplicated.
- Storage is a main register (M) plus, when the skid buffer is compiled in, a skid register (S). Occupancy states:
  - EMPTY: nothing held.
  - ONE: M valid.
  - TWO: M and S valid; skid builds only.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on deliver without accept.
  - ONE→ONE on deliver with accept, or on neither.
  - ONE→TWO on accept without deliver.
  - TWO→ONE on deliver: S moves into M. No accept is possible in TWO.
- Simultaneous accept and deliver in ONE: M loads the new result in the same edge. Throughput is 1 per cycle.
- Out and OutMode hold stable while OutValid && !OutReady.
- In and Mode are ignored while InValid is low or InReady is low.

## Timing
- Reset (asynchronous, any time, including mid-transfer):
  - OutValid=0, Out=0, OutMode=00; state EMPTY; S cleared.
  - InReady=1 with skid compiled in. Without skid, InReady also evaluates to 1 (OutValid=0).
  - In-flight results are discarded.
- First accept is possible on the first rising edge after Reset deasserts.
- Latency: a result accepted at edge N has OutValid=1 after edge N, visible in cycle N+1.
- With skid, InReady is a register output: InReady = (state != TWO). There is no combinational path from OutReady to InReady.
- Without skid, InReady = !OutValid || OutReady. This is combinational from OutReady.
- OutValid is a register output. Out and OutMode come straight from M flops.

## Configuration
- IMMEXT_SKID_EN defined: S register present. State TWO is reachable. InReady is registered, as above.
- IMMEXT_SKID_EN undefined: no S register. State TWO is unreachable. InReady = !OutValid || OutReady.
- Results, ordering, latency and reset values are identical in both builds.
- The bench runs under both builds.

## Test plan
- Modes at 16→32: In=16'h8000, Mode 00 → Out=32'hFFFF8000. Mode 01 → 32'h00008000. In=16'h1234, Mode 10 → 32'h12340000. In=16'hFFFF, Mode 11 → 32'hFFFFFFFC. In=16'h0004, Mode 11 → 32'h00000010. OutMode matches in each case.
- Streaming: OutReady=1, inputs 1..8 on consecutive cycles, Mode 00. Expect 8 outputs on consecutive cycles, first one cycle after the first accept, InReady never low.
- Backpressure, skid build: OutReady=0, offer A=16'h0001 then B=16'h0002. Expect both accepted, then InReady=0. Raise OutReady: Out=1 then 2, then InReady=1. Non-skid build: B is held off until A delivers.
- Stall stability: OutValid=1, OutReady=0 for 5 cycles while In toggles. Out and OutMode stay unchanged.
- Reset mid-operation: in state TWO, pulse Reset between clock edges. OutValid=0, Out=0 and InReady=1 immediately. No stale result appears after release.
- Parameters IN_WIDTH=8, OUT_WIDTH=16: In=8'h80, Mode 11 → 16'hFE00. Mode 10 → 16'h8000.

Source files
------------

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// imm_extend_pipe: registered immediate extension (sign/zero/upper/branch) behind a valid/ready handshake.
// Define IMMEXT_SKID_EN to add the skid register and a registered InReady.
module imm_extend_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [IN_WIDTH-1:0]  In,
  input  logic [1:0]           Mode,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [OUT_WIDTH-1:0] Out,
  output logic [1:0]           OutMode
);

  localparam int EXT = OUT_WIDTH - IN_WIDTH;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  if (IN_WIDTH < 2 || OUT_WIDTH < IN_WIDTH + 2) begin : g_param_check
    $error("imm_extend_pipe: need IN_WIDTH >= 2 and OUT_WIDTH >= IN_WIDTH+2");
  end

  logic [OUT_WIDTH-1:0] sext;
  logic [OUT_WIDTH-1:0] ext;
  occ_t                 state;
  occ_t                 state_n;
  logic                 accept;
  logic                 deliver;
  logic                 load_m_new;
  logic [OUT_WIDTH-1:0] m_data;
  logic [1:0]           m_mode;

  assign sext = {{EXT{In[IN_WIDTH-1]}}, In};

  // Branch form drops the top two sign bits by shifting the full-width sign extension.
  always_comb begin
    ext = sext;
    case (Mode)
      MODE_SIGN:   ext = sext;
      MODE_ZERO:   ext = {{EXT{1'b0}}, In};
      MODE_UPPER:  ext = {In, {EXT{1'b0}}};
      MODE_BRANCH: ext = sext << 2;
      default:     ext = sext;
    endcase
  end

  assign OutValid = (state != EMPTY);
  assign accept   = InValid && InReady;
  assign deliver  = OutValid && OutReady;
  assign Out      = m_data;
  assign OutMode  = m_mode;

`ifdef IMMEXT_SKID_EN
  logic                 load_m_skid;
  logic                 load_s;
  logic [OUT_WIDTH-1:0] s_data;
  logic [1:0]           s_mode;

  assign InReady = (state != TWO);
`else
  assign InReady = !OutValid || OutReady;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    load_m_new = 1'b0;
`ifdef IMMEXT_SKID_EN
    load_m_skid = 1'b0;
    load_s      = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (accept) begin
          state_n    = ONE;
          load_m_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_m_new = 1'b1;
        end else if (deliver) begin
          state_n = EMPTY;
`ifdef IMMEXT_SKID_EN
        end else if (accept) begin
          state_n = TWO;
          load_s  = 1'b1;
`endif
        end
      end
      TWO: begin
`ifdef IMMEXT_SKID_EN
        if (deliver) begin
          state_n     = ONE;
          load_m_skid = 1'b1;
        end
`else
        state_n = EMPTY;
`endif
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_data <= '0;
      m_mode <= '0;
    end else if (load_m_new) begin
      m_data <= ext;
      m_mode <= Mode;
`ifdef IMMEXT_SKID_EN
    end else if (load_m_skid) begin
      m_data <= s_data;
      m_mode <= s_mode;
`endif
    end
  end

`ifdef IMMEXT_SKID_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_data <= '0;
      s_mode <= '0;
    end else if (load_s) begin
      s_data <= ext;
      s_mode <= Mode;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// tb_imm_extend_pipe: directed and random checks of imm_extend_pipe against an arithmetic reference queue.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  mode, out_mode;
  logic [31:0] out_data;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  in_data2;
  logic [1:0]  mode2, out_mode2;
  logic [15:0] out_data2;

  imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
    .Clk(clk), .Reset(rst),
    .InValid(in_valid), .InReady(in_ready), .In(in_data), .Mode(mode),
    .OutValid(out_valid), .OutReady(out_ready), .Out(out_data), .OutMode(out_mode)
  );

  imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut_small (
    .Clk(clk), .Reset(rst),
    .InValid(in_valid2), .InReady(in_ready2), .In(in_data2), .Mode(mode2),
    .OutValid(out_valid2), .OutReady(out_ready2), .Out(out_data2), .OutMode(out_mode2)
  );

`ifdef IMMEXT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: interpret In as a signed/unsigned number and reduce the result modulo 2^ow.
  function automatic logic [63:0] model(input int iw, input int ow,
                                        input logic [63:0] v, input logic [1:0] m);
    longint sv, r, modv;
    modv = longint'(1) << ow;
    sv = (v >= 64'(longint'(1) << (iw - 1))) ? longint'(v) - (longint'(1) << iw) : longint'(v);
    case (m)
      2'd0:    r = sv;
      2'd1:    r = longint'(v);
      2'd2:    r = longint'(v) * (longint'(1) << (ow - iw));
      default: r = sv * 4;
    endcase
    r = ((r % modv) + modv) % modv;
    return 64'(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the queue, predict handshakes, advance to edge+1.
  task automatic cycle();
    exp_t e;
    bit   exp_rdy, acc, del;
    #1;
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (q.size() != 0) begin
      check("out", 64'(out_data), 64'(q[0].d));
      check("out_mode", 64'(out_mode), 64'(q[0].m));
    end
    del = (q.size() != 0) && out_ready;
    acc = in_valid && exp_rdy;
    if (del) e = q.pop_front();
    if (acc) begin
      e.d = 32'(model(16, 32, 64'(in_data), mode));
      e.m = mode;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic one_shot(input string tag, input logic [15:0] v, input logic [1:0] m,
                          input logic [31:0] exp);
    in_valid  = 1'b1;
    in_data   = v;
    mode      = m;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check(tag, 64'(out_data), 64'(exp));
    check({tag, "_mode"}, 64'(out_mode), 64'(m));
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_data = '0; mode = '0; out_ready = 0;
    in_valid2 = 0; in_data2 = '0; mode2 = '0; out_ready2 = 0;

    #12;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out", 64'(out_data), 0);
    check("rst_out_mode", 64'(out_mode), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    one_shot("sign_8000",    16'h8000, 2'b00, 32'hFFFF8000);
    one_shot("zero_8000",    16'h8000, 2'b01, 32'h00008000);
    one_shot("upper_1234",   16'h1234, 2'b10, 32'h12340000);
    one_shot("branch_ffff",  16'hFFFF, 2'b11, 32'hFFFFFFFC);
    one_shot("branch_0004",  16'h0004, 2'b11, 32'h00000010);

    // Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i); mode = 2'b00;
      cycle();
      check("stream_out", 64'(out_data), 64'(i));
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001; mode = 2'b00;
    cycle();
    in_data = 16'h0002;
    cycle();
`ifdef IMMEXT_SKID_EN
    in_valid = 1'b0;
    check("bp_full_not_ready", 64'(in_ready), 0);
    out_ready = 1'b1;
    cycle();
    check("bp_second_out", 64'(out_data), 64'h2);
    check("bp_ready_again", 64'(in_ready), 1);
    cycle();
`else
    check("bp_held_off", 64'(in_ready), 0);
    check("bp_first_out", 64'(out_data), 64'h1);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("bp_second_out", 64'(out_data), 64'h2);
    cycle();
`endif

    // Stall stability while In/Mode wander.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00AB; mode = 2'b01;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = ~in_data;
      mode    = mode + 2'd1;
      cycle();
      check("stall_out", 64'(out_data), 64'h000000AB);
      check("stall_mode", 64'(out_mode), 64'h1);
    end
    out_ready = 1'b1;
    cycle();

    // Reset between edges while full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0055; mode = 2'b00;
    cycle();
    in_data = 16'h0066;
    cycle();
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_out", 64'(out_data), 0);
    check("mid_rst_out_mode", 64'(out_mode), 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    q.delete();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      mode      = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check("drain_empty", 64'(q.size()), 0);

    // Narrow instance, 8 -> 16.
    in_valid2 = 1'b1; in_data2 = 8'h80; mode2 = 2'b11; out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    check("w8_branch_valid", 64'(out_valid2), 1);
    check("w8_branch", 64'(out_data2), 64'hFE00);
    mode2 = 2'b10;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    check("w8_upper", 64'(out_data2), 64'h8000);
    check("w8_upper_mode", 64'(out_mode2), 64'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
